// File: rtl/branch_resolve_queue.sv
// In-order queue of outstanding branch predictions. Resolves the oldest entry,
// drives the predictor update pair, flushes wrong-path entries and keeps statistics.
module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_valid,
  input  logic             pred_taken,
  input  logic             resolve_valid,
  input  logic             resolve_taken,
  output logic             full,
  output logic             empty,
  output logic             result,
  output logic             taken,
  output logic             mispredict,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic             err_overflow,
  output logic             err_underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;

  logic pop;
  logic miss;
  logic push;
  logic drop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  // Pop is decided first; a mispredicting pop kills any same-cycle push as wrong-path.
  assign pop  = resolve_valid && !empty;
  assign miss = pop && (mem[rd_ptr] != resolve_taken);
  assign push = pred_valid && !miss && (!full || pop);
  assign drop = pred_valid && full && !pop;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= pred_taken;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (miss) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + (AW+1)'(1);
      end else if (pop && !push) begin
        count <= count - (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result     <= 1'b0;
      taken      <= 1'b0;
      mispredict <= 1'b0;
    end else begin
      result     <= pop;
      taken      <= pop && resolve_taken;
      mispredict <= miss;
    end
  end

  // Statistics saturate at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count     <= '0;
      miss_count    <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (pop && !miss && (hit_count != {CNT_W{1'b1}})) begin
        hit_count <= hit_count + CNT_W'(1);
      end
      if (miss && (miss_count != {CNT_W{1'b1}})) begin
        miss_count <= miss_count + CNT_W'(1);
      end
      if (drop) begin
        err_overflow <= 1'b1;
      end
      if (resolve_valid && empty) begin
        err_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Randomised and directed bench for branch_resolve_queue, checked every cycle
// against a queue-based model of the prediction FIFO.
module tb_branch_resolve_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             pred_valid;
  logic             pred_taken;
  logic             resolve_valid;
  logic             resolve_taken;
  logic             full;
  logic             empty;
  logic             result;
  logic             taken;
  logic             mispredict;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;
  logic             err_overflow;
  logic             err_underflow;

  int vectors = 0;
  int errors  = 0;

  branch_resolve_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .pred_valid(pred_valid),
    .pred_taken(pred_taken),
    .resolve_valid(resolve_valid),
    .resolve_taken(resolve_taken),
    .full(full),
    .empty(empty),
    .result(result),
    .taken(taken),
    .mispredict(mispredict),
    .hit_count(hit_count),
    .miss_count(miss_count),
    .err_overflow(err_overflow),
    .err_underflow(err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a plain queue of predicted directions plus expected outputs.
  bit q[$];
  int exp_hit;
  int exp_miss;
  bit exp_result;
  bit exp_taken;
  bit exp_mis;
  bit exp_ovf;
  bit exp_unf;
  bit m_miss;
  bit m_head;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      exp_hit = 0; exp_miss = 0;
      exp_result = 0; exp_taken = 0; exp_mis = 0;
      exp_ovf = 0; exp_unf = 0;
    end else begin
      exp_result = 0; exp_taken = 0; exp_mis = 0;
      m_miss = 0;
      if (resolve_valid) begin
        if (q.size() == 0) begin
          exp_unf = 1;
        end else begin
          m_head = q.pop_front();
          m_miss = (m_head != resolve_taken);
          exp_result = 1;
          exp_taken = resolve_taken;
          exp_mis = m_miss;
          if (m_miss) begin
            q.delete();
            if (exp_miss < SAT) exp_miss++;
          end else if (exp_hit < SAT) begin
            exp_hit++;
          end
        end
      end
      if (pred_valid && !m_miss) begin
        if (q.size() < DEPTH) q.push_back(pred_taken);
        else exp_ovf = 1;
      end
    end
  end

  task automatic checkOne(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput();
    checkOne("full",          32'(full),          32'(q.size() == DEPTH));
    checkOne("empty",         32'(empty),         32'(q.size() == 0));
    checkOne("result",        32'(result),        32'(exp_result));
    checkOne("taken",         32'(taken),         32'(exp_taken));
    checkOne("mispredict",    32'(mispredict),    32'(exp_mis));
    checkOne("hit_count",     32'(hit_count),     exp_hit);
    checkOne("miss_count",    32'(miss_count),    exp_miss);
    checkOne("err_overflow",  32'(err_overflow),  32'(exp_ovf));
    checkOne("err_underflow", 32'(err_underflow), 32'(exp_unf));
  endtask

  always @(negedge clk) checkOutput();

  // Called at a negedge; drives inputs for one cycle and returns at the next negedge.
  task automatic applyStimulus(input bit pv, input bit pt, input bit rv, input bit rt);
    pred_valid = pv; pred_taken = pt; resolve_valid = rv; resolve_taken = rt;
    @(posedge clk);
    @(negedge clk);
    pred_valid = 0; pred_taken = 0; resolve_valid = 0; resolve_taken = 0;
  endtask

  task automatic doReset();
    #2 rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic resolveHead();
    applyStimulus(0, 0, 1, q[0]);
  endtask

  bit pv, pt, rv, rt;

  initial begin
    rst = 1'b1;
    pred_valid = 0; pred_taken = 0; resolve_valid = 0; resolve_taken = 0;
    @(negedge clk);
    checkOne("reset_empty", 32'(empty), 1);
    checkOne("reset_full",  32'(full),  0);
    #2 rst = 1'b0;
    @(negedge clk);

    // In-order resolution of T,N,T
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0);
    checkOne("tnt_not_empty", 32'(empty), 0);
    applyStimulus(0, 0, 1, 1);
    checkOne("tnt_r1_taken", 32'(taken), 1);
    checkOne("tnt_r1_result", 32'(result), 1);
    applyStimulus(0, 0, 1, 0);
    checkOne("tnt_r2_taken", 32'(taken), 0);
    applyStimulus(0, 0, 1, 1);
    checkOne("tnt_r3_mis", 32'(mispredict), 0);
    applyStimulus(0, 0, 0, 0);
    checkOne("tnt_hits", 32'(hit_count), 3);
    checkOne("tnt_result_low", 32'(result), 0);
    checkOne("tnt_empty", 32'(empty), 1);

    // Fill, overflow, push+pop at full
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    checkOne("fill_full", 32'(full), 1);
    applyStimulus(1, 0, 0, 0);
    checkOne("ovf_set", 32'(err_overflow), 1);
    applyStimulus(1, 0, 1, 1);
    checkOne("pushpop_full", 32'(full), 1);
    resolveHead(); resolveHead(); resolveHead();
    applyStimulus(0, 0, 1, 0);
    checkOne("last_entry_hit", 32'(hit_count), 8);
    checkOne("drained", 32'(empty), 1);

    // Misprediction flush with a wrong-path push
    doReset();
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 1, 0);
    checkOne("flush_mis", 32'(mispredict), 1);
    checkOne("flush_taken", 32'(taken), 0);
    checkOne("flush_missc", 32'(miss_count), 1);
    checkOne("flush_empty", 32'(empty), 1);
    checkOne("flush_noovf", 32'(err_overflow), 0);

    // Resolve while empty, with a push that must still land
    doReset();
    applyStimulus(1, 0, 1, 1);
    checkOne("unf_set", 32'(err_underflow), 1);
    checkOne("unf_no_result", 32'(result), 0);
    checkOne("unf_hits", 32'(hit_count), 0);
    applyStimulus(0, 0, 1, 0);
    checkOne("unf_then_hit", 32'(hit_count), 1);

    // Hit counter saturation with continuous push/pop and pointer wrap
    doReset();
    for (int i = 0; i < 310; i++) begin
      pt = 1'($urandom);
      if (q.size() > 0) applyStimulus(1, pt, 1, q[0]);
      else applyStimulus(1, pt, 0, 0);
    end
    checkOne("hit_saturated", 32'(hit_count), SAT);

    // Random traffic, mostly correct resolutions
    doReset();
    for (int i = 0; i < 2000; i++) begin
      pv = ($urandom_range(0, 99) < 60);
      pt = 1'($urandom);
      rv = ($urandom_range(0, 99) < 50);
      if (q.size() > 0 && $urandom_range(0, 9) < 8) rt = q[0];
      else rt = 1'($urandom);
      applyStimulus(pv, pt, rv, rt);
    end

    // Asynchronous reset with entries and a result pulse pending
    doReset();
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 0, 1, 1);
    checkOne("pre_areset_result", 32'(result), 1);
    #2 rst = 1'b1;
    #1;
    checkOne("areset_empty", 32'(empty), 1);
    checkOne("areset_result", 32'(result), 0);
    checkOne("areset_hits", 32'(hit_count), 0);
    checkOne("areset_taken", 32'(taken), 0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(0, 0, 1, 1);
    checkOne("post_areset_hit", 32'(hit_count), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
